// File: rtl/branch_recovery_unit_pkg.sv
// Shared types and helpers for branch recovery. The ROB and the LSQ also use rob_age().
// The pending-record fields are sized for the widest supported configuration.
package branch_recovery_unit_pkg;

  localparam int unsigned BruRobMax  = 16;
  localparam int unsigned BruAddrMax = 64;

  typedef enum logic [1:0] {
    BRU_IDLE,
    BRU_PENDING,
    BRU_FLUSH,
    BRU_RESTORE
  } bru_state_t;

  typedef struct packed {
    logic [BruRobMax-1:0]  rob_id;
    logic [BruAddrMax-1:0] target;
  } bru_pending_t;

  // Distance of id from the ROB head, modulo the ROB depth; smaller means older.
  function automatic logic [BruRobMax-1:0] rob_age(input logic [BruRobMax-1:0] id,
                                                  input logic [BruRobMax-1:0] head,
                                                  input int unsigned          width);
    logic [BruRobMax-1:0] mask;
    mask = BruRobMax'((32'd1 << width) - 32'd1);
    return (id - head) & mask;
  endfunction

endpackage

// File: rtl/branch_recovery_unit.sv
// Tracks the oldest outstanding mispredicted branch, flushes and redirects when it retires,
// stalls the front end during restore, and emits predictor-update records.
module branch_recovery_unit
  import branch_recovery_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned ROB_WIDTH      = 5,
  parameter int unsigned RESTORE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_branch_valid,
  input  logic                  commit_jump_valid,
  input  logic [ROB_WIDTH-1:0]  commit_branch_rob_id,
  input  logic                  commit_mispredict,
  input  logic                  commit_actual_taken,
  input  logic [ADDR_WIDTH-1:0] commit_actual_target,
  input  logic [ADDR_WIDTH-1:0] commit_nextPC,
  input  logic [ADDR_WIDTH-1:0] commit_update_pc,
  input  logic [ROB_WIDTH-1:0]  rob_head,
  input  logic                  retire_valid,
  input  logic [ROB_WIDTH-1:0]  retire_rob_id,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  recovery_busy,
  output logic                  bp_update_valid,
  output logic [ADDR_WIDTH-1:0] bp_update_pc,
  output logic [ADDR_WIDTH-1:0] bp_update_target,
  output logic                  bp_update_taken,
  output logic                  bp_update_is_jump
);

  localparam int unsigned CntW = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;

  bru_state_t            state_q;
  bru_pending_t          pend_q;
  logic [CntW-1:0]       restore_cnt_q;

  logic [ADDR_WIDTH-1:0] new_target;
  logic [BruRobMax-1:0]  new_age;
  logic [BruRobMax-1:0]  pend_age;
  logic                  commit_accept;
  logic                  capture;
  logic                  retire_hit;
  logic                  unused_pend;

  always_comb begin
    new_target    = (commit_actual_taken || commit_jump_valid) ? commit_actual_target
                                                               : commit_nextPC;
    new_age       = rob_age(BruRobMax'(commit_branch_rob_id), BruRobMax'(rob_head), ROB_WIDTH);
    pend_age      = rob_age(pend_q.rob_id, BruRobMax'(rob_head), ROB_WIDTH);
    // Commits seen during FLUSH/RESTORE belong to squashed ops.
    commit_accept = commit_branch_valid &&
                    ((state_q == BRU_IDLE) || (state_q == BRU_PENDING));
    capture       = commit_accept && commit_mispredict;
    // Only the registered pending id can trigger; a same-cycle capture cannot.
    retire_hit    = retire_valid && (retire_rob_id == pend_q.rob_id[ROB_WIDTH-1:0]);
  end

  assign unused_pend = ^pend_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= BRU_IDLE;
      pend_q            <= '0;
      restore_cnt_q     <= '0;
      flush             <= 1'b0;
      redirect_valid    <= 1'b0;
      redirect_pc       <= '0;
      recovery_busy     <= 1'b0;
      bp_update_valid   <= 1'b0;
      bp_update_pc      <= '0;
      bp_update_target  <= '0;
      bp_update_taken   <= 1'b0;
      bp_update_is_jump <= 1'b0;
    end else begin
      flush           <= 1'b0;
      redirect_valid  <= 1'b0;
      bp_update_valid <= commit_accept;
      if (commit_accept) begin
        bp_update_pc      <= commit_update_pc;
        bp_update_target  <= commit_actual_target;
        bp_update_taken   <= commit_actual_taken;
        bp_update_is_jump <= commit_jump_valid;
      end

      case (state_q)
        BRU_IDLE: begin
          recovery_busy <= 1'b0;
          if (capture) begin
            pend_q  <= '{rob_id: BruRobMax'(commit_branch_rob_id),
                         target: BruAddrMax'(new_target)};
            state_q <= BRU_PENDING;
          end
        end
        BRU_PENDING: begin
          if (retire_hit) begin
            state_q        <= BRU_FLUSH;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= pend_q.target[ADDR_WIDTH-1:0];
            recovery_busy  <= 1'b1;
            pend_q         <= '0;
          end else if (capture && (new_age < pend_age)) begin
            pend_q <= '{rob_id: BruRobMax'(commit_branch_rob_id),
                        target: BruAddrMax'(new_target)};
          end
        end
        BRU_FLUSH: begin
          state_q       <= BRU_RESTORE;
          restore_cnt_q <= CntW'(RESTORE_CYCLES - 1);
        end
        BRU_RESTORE: begin
          if (restore_cnt_q == '0) begin
            state_q       <= BRU_IDLE;
            recovery_busy <= 1'b0;
          end else begin
            restore_cnt_q <= restore_cnt_q - 1'b1;
          end
        end
        default: state_q <= BRU_IDLE;
      endcase
    end
  end

endmodule
